// File: rtl/sum_decoder.sv
// Recovers operand B from a wrapped sum and known operand A, one bit per cycle, LSB first.
// Optional wrap detection is compiled in by defining SUM_DECODER_WRAP_EN.
module sum_decoder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] sum_in,
   input  logic [WIDTH-1:0] a_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] b_out,
   output logic             wrapped
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sumSh_q, sumSh_d;
   logic [WIDTH-1:0] aSh_q, aSh_d;
   logic [WIDTH-1:0] resSh_q, resSh_d;
   logic [WIDTH-1:0] bOut_q, bOut_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             borrow_q, borrow_d;
   logic             diffBit;
   logic             borrowOut;
   logic             lastShift;

   assign diffBit   = sumSh_q[0] ^ aSh_q[0] ^ borrow_q;
   assign borrowOut = (~sumSh_q[0] & aSh_q[0]) | (~(sumSh_q[0] ^ aSh_q[0]) & borrow_q);
   assign lastShift = (state_q == SHIFT) && (cnt_q == LAST_BIT);

   always_comb begin
      state_d  = state_q;
      sumSh_d  = sumSh_q;
      aSh_d    = aSh_q;
      resSh_d  = resSh_q;
      bOut_d   = bOut_q;
      cnt_d    = cnt_q;
      borrow_d = borrow_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               sumSh_d  = sum_in;
               aSh_d    = a_in;
               resSh_d  = '0;
               cnt_d    = '0;
               borrow_d = 1'b0;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            sumSh_d  = sumSh_q >> 1;
            aSh_d    = aSh_q >> 1;
            resSh_d  = {diffBit, resSh_q[WIDTH-1:1]};
            borrow_d = borrowOut;
            cnt_d    = cnt_q + CW'(1);
            // The result becomes visible only once all bits are in, so b_out never shows partial data
            if (lastShift) begin
               bOut_d  = {diffBit, resSh_q[WIDTH-1:1]};
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         sumSh_q  <= '0;
         aSh_q    <= '0;
         resSh_q  <= '0;
         bOut_q   <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sumSh_q  <= sumSh_d;
         aSh_q    <= aSh_d;
         resSh_q  <= resSh_d;
         bOut_q   <= bOut_d;
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
      end
   end

`ifdef SUM_DECODER_WRAP_EN
   logic wrapped_q, wrapped_d;

   // The borrow out of the MSB is set exactly when sum_in < a_in unsigned
   always_comb begin
      wrapped_d = wrapped_q;
      if (lastShift) begin
         wrapped_d = borrowOut;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrapped_q <= 1'b0;
      end else begin
         wrapped_q <= wrapped_d;
      end
   end

   assign wrapped = wrapped_q;
`else
   assign wrapped = 1'b0;
`endif

   assign busy  = (state_q != IDLE);
   assign done  = (state_q == DONE);
   assign b_out = bOut_q;

endmodule

// File: tb/tb_sum_decoder.sv
// Self-checking bench for sum_decoder: table vectors, corner-case sequences and random pairs
// against a modular-arithmetic reference. Honours SUM_DECODER_WRAP_EN when defined.
module tb_sum_decoder;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] sum_in;
   logic [WIDTH-1:0] a_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] b_out;
   logic             wrapped;

   int checks = 0;
   int passes = 0;

   typedef struct {
      logic [7:0] sumV;
      logic [7:0] aV;
      logic [7:0] expB;
      logic       expW;
   } vec_t;

   sum_decoder #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .sum_in (sum_in),
      .a_in   (a_in),
      .busy   (busy),
      .done   (done),
      .b_out  (b_out),
      .wrapped(wrapped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] refB(input logic [7:0] s, input logic [7:0] a);
      int d;
      d = (int'(s) - int'(a) + 256) % 256;
      return d[7:0];
   endfunction

   function automatic logic refWrap(input logic [7:0] s, input logic [7:0] a);
`ifdef SUM_DECODER_WRAP_EN
      return (int'(s) < int'(a));
`else
      return 1'b0;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until done rises or the bound expires; b_out must keep prevB until done
   task automatic waitDone(input int bound, input logic [7:0] prevB, output int n);
      n = 0;
      while (n < bound) begin
         tick();
         n++;
         if (done) return;
         checkOutput("b_out hold during decode", b_out, prevB);
      end
      checkOutput("done timeout", 0, 1);
   endtask

   task automatic applyStimulus(input logic [7:0] s, input logic [7:0] a);
      logic [7:0] prevB;
      int n;
      prevB  = b_out;
      sum_in = s;
      a_in   = a;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      checkOutput("busy after start", busy, 1);
      checkOutput("done after start", done, 0);
      sum_in = 8'($urandom);
      a_in   = 8'($urandom);
      waitDone(20, prevB, n);
      checkOutput("latency cycles", n + 1, 9);
      checkOutput("b_out", b_out, refB(s, a));
      checkOutput("wrapped", wrapped, refWrap(s, a));
      checkOutput("a+b wraps to sum", 8'(a + b_out), s);
      tick();
      checkOutput("done one cycle", done, 0);
      checkOutput("busy back to idle", busy, 0);
   endtask

   initial begin
      vec_t vecs[6];
      logic [7:0] heldB;
      int n;
      int doneCount;

      vecs[0] = '{8'h50, 8'h20, 8'h30, 1'b0};
      vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1};
      vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
      vecs[3] = '{8'hFF, 8'h01, 8'hFE, 1'b0};
      vecs[4] = '{8'h7F, 8'h7F, 8'h00, 1'b0};
      vecs[5] = '{8'h00, 8'hFF, 8'h01, 1'b1};

      rst    = 1'b1;
      start  = 1'b0;
      sum_in = '0;
      a_in   = '0;
      #3;
      checkOutput("reset busy", busy, 0);
      checkOutput("reset done", done, 0);
      checkOutput("reset b_out", b_out, 0);
      checkOutput("reset wrapped", wrapped, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Table vectors: expected values written by hand, wrap flag gated by build option
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].sumV, vecs[i].aV);
         checkOutput("table b_out", b_out, vecs[i].expB);
`ifdef SUM_DECODER_WRAP_EN
         checkOutput("table wrapped", wrapped, vecs[i].expW);
`else
         checkOutput("table wrapped", wrapped, 0);
`endif
      end

      // Idle with start low: outputs hold while inputs wander
      heldB = b_out;
      for (int i = 0; i < 5; i++) begin
         sum_in = 8'($urandom);
         a_in   = 8'($urandom);
         tick();
         checkOutput("idle b_out hold", b_out, heldB);
         checkOutput("idle busy", busy, 0);
      end

      // Start during SHIFT is ignored
      sum_in = 8'h50;
      a_in   = 8'h20;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      tick();
      tick();
      tick();
      sum_in = 8'h11;
      a_in   = 8'h99;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      doneCount = 0;
      for (int i = 0; i < 25; i++) begin
         if (done) doneCount++;
         tick();
      end
      checkOutput("ignored start done count", doneCount, 1);
      checkOutput("ignored start b_out", b_out, 8'h30);

      // Reset mid-SHIFT clears outputs at once and suppresses done
      applyStimulus(8'h10, 8'h20);
      sum_in = 8'h44;
      a_in   = 8'h11;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      tick();
      tick();
      tick();
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async reset busy", busy, 0);
      checkOutput("async reset done", done, 0);
      checkOutput("async reset b_out", b_out, 0);
      checkOutput("async reset wrapped", wrapped, 0);
      tick();
      rst = 1'b0;
      doneCount = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done) doneCount++;
      end
      checkOutput("no done after abort", doneCount, 0);
      applyStimulus(8'hFF, 8'h01);

      // start held high: decodes every WIDTH+2 cycles, operands sampled per capture
      sum_in = 8'h03;
      a_in   = 8'h01;
      start  = 1'b1;
      heldB  = b_out;
      tick();
      sum_in = 8'h00;
      a_in   = 8'h01;
      waitDone(20, heldB, n);
      checkOutput("b2b first latency", n, 8);
      checkOutput("b2b first b_out", b_out, 8'h02);
      waitDone(20, 8'h02, n);
      start = 1'b0;
      checkOutput("b2b period", n, 10);
      checkOutput("b2b second b_out", b_out, 8'hFF);
      checkOutput("b2b second wrapped", wrapped, refWrap(8'h00, 8'h01));
      tick();
      tick();

      // Random operand pairs against the arithmetic reference
      for (int i = 0; i < 1000; i++) begin
         applyStimulus(8'($urandom), 8'($urandom_range(255, 0)));
      end

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
